// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and requester IDs for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_INST = 1'b0;
    localparam req_id_t REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signals of the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     i_inst_req;
    logic [ADDRESS_WIDTH-1:0] i_inst_addr;
    logic                     o_inst_ack;
    logic [DATA_WIDTH-1:0]    o_inst_rdata;

    logic                     i_data_req;
    logic                     i_data_we;
    logic [3:0]               i_data_be;
    logic [ADDRESS_WIDTH-1:0] i_data_addr;
    logic [DATA_WIDTH-1:0]    i_data_wdata;
    logic                     o_data_ack;
    logic [DATA_WIDTH-1:0]    o_data_rdata;

    logic                     o_mem_req;
    logic                     o_mem_we;
    logic [3:0]               o_mem_be;
    logic [ADDRESS_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0]    o_mem_wdata;
    logic                     i_mem_ack;
    logic [DATA_WIDTH-1:0]    i_mem_rdata;

    logic                     o_busy;

    modport slave (
        input  i_inst_req, i_inst_addr,
        input  i_data_req, i_data_we, i_data_be, i_data_addr, i_data_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_inst_ack, o_inst_rdata, o_data_ack, o_data_rdata,
        output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output o_busy
    );

    modport master (
        output i_inst_req, i_inst_addr,
        output i_data_req, i_data_we, i_data_be, i_data_addr, i_data_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_inst_ack, o_inst_rdata, o_data_ack, o_data_rdata,
        input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  o_busy
    );
endinterface

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational 2-way round-robin choice between INST and DATA
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic    inst_req,
    input  logic    data_req,
    input  req_id_t last_grant,
    output logic    any_req,
    output req_id_t pick
);
    always_comb begin
        any_req = inst_req | data_req;
        if (inst_req && data_req)
            pick = (last_grant == REQ_DATA) ? REQ_INST : REQ_DATA;
        else if (data_req)
            pick = REQ_DATA;
        else
            pick = REQ_INST;
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin INST/DATA main-memory arbiter; MEM_ARB_BURST_LOCK_EN holds grant for bursts
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BURST);
`ifdef MEM_ARB_BURST_LOCK_EN
    localparam int BURST_LIMIT = MAX_BURST;
`else
    // Without locking every word is its own grant, so the counter never leaves 0.
    localparam int BURST_LIMIT = 1;
`endif

    arb_state_t       state;
    req_id_t          last_grant;
    logic [CNT_W-1:0] burst_cnt;

    logic    any_req;
    req_id_t pick;
    logic    grant_i;
    logic    grant_d;
    logic    granted_req;
    logic    last_word;

    mem_arb_picker u_picker (
        .inst_req   (bus.i_inst_req),
        .data_req   (bus.i_data_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .pick       (pick)
    );

    assign grant_i     = (state == ST_GRANT_I);
    assign grant_d     = (state == ST_GRANT_D);
    assign granted_req = (grant_i & bus.i_inst_req) | (grant_d & bus.i_data_req);
    assign last_word   = (burst_cnt == CNT_W'(BURST_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= REQ_DATA;
            burst_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state      <= (pick == REQ_INST) ? ST_GRANT_I : ST_GRANT_D;
                        last_grant <= pick;
                        burst_cnt  <= '0;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    // A dropped request releases even mid-word; memory must tolerate the abort.
                    if (!granted_req) begin
                        state     <= ST_IDLE;
                        burst_cnt <= '0;
                    end else if (bus.i_mem_ack) begin
                        if (last_word) begin
                            state     <= ST_IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_mem_req   = granted_req;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_be    = 4'h0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        if (grant_i) begin
            bus.o_mem_be   = 4'hF;
            bus.o_mem_addr = bus.i_inst_addr;
        end else if (grant_d) begin
            bus.o_mem_we    = bus.i_data_we;
            bus.o_mem_be    = bus.i_data_be;
            bus.o_mem_addr  = bus.i_data_addr;
            bus.o_mem_wdata = bus.i_data_wdata;
        end
        bus.o_inst_ack   = grant_i & bus.i_mem_ack;
        bus.o_data_ack   = grant_d & bus.i_mem_ack;
        bus.o_inst_rdata = grant_i ? bus.i_mem_rdata : '0;
        bus.o_data_rdata = grant_d ? bus.i_mem_rdata : '0;
        bus.o_busy       = (state != ST_IDLE);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a cycle-level ownership model
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 16;
`ifdef MEM_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dtxn_t;

    int total = 0;
    int bad   = 0;

    // Ownership model: 0 = nobody, 1 = INST, 2 = DATA.
    int m_owner, m_last, m_words;

    dtxn_t         dq[$];
    int            inst_left;
    logic [AW-1:0] inst_next;
    int            mem_wait, mem_lat, fixed_lat;
    string         trace;
    int            scn_cyc, first_mreq;
    logic [68:0]   last_dcmd;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] seq_code(input string s);
        logic [95:0] bits;
        int n;
        bits = '0;
        n = 0;
        for (int k = 0; k < s.len(); k++)
            if (s[k] == "I" || s[k] == "D") begin
                bits = {bits[94:0], (s[k] == "D")};
                n++;
            end
        return {n[31:0], bits};
    endfunction

    function automatic int idle_between(input string s);
        int first, last, n;
        first = -1; last = -1; n = 0;
        for (int k = 0; k < s.len(); k++)
            if (s[k] == "I" || s[k] == "D") begin
                if (first < 0) first = k;
                last = k;
            end
        for (int k = first + 1; k < last; k++)
            if (s[k] == ".") n++;
        return n;
    endfunction

    function automatic string rep(input string c, input int n);
        string r;
        r = "";
        for (int k = 0; k < n; k++) r = {r, c};
        return r;
    endfunction

    task automatic new_lat();
        mem_wait = 0;
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
    endtask

    task automatic clear_inputs();
        bus.i_inst_req   = 1'b0;
        bus.i_inst_addr  = '0;
        bus.i_data_req   = 1'b0;
        bus.i_data_we    = 1'b0;
        bus.i_data_be    = 4'h0;
        bus.i_data_addr  = '0;
        bus.i_data_wdata = '0;
        bus.i_mem_ack    = 1'b0;
        bus.i_mem_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        dq.delete();
        inst_left = 0;
        m_owner = 0; m_last = 2; m_words = 0;
        new_lat();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic start_scn();
        trace = "";
        scn_cyc = 0;
        first_mreq = -1;
        last_dcmd = '0;
    endtask

    task automatic cycle();
        logic          e_req, e_we, e_iack, e_dack;
        logic [3:0]    e_be;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int            r;
        #1;
        bus.i_inst_req  = (inst_left > 0);
        bus.i_inst_addr = inst_next;
        if (dq.size() > 0) begin
            bus.i_data_req   = 1'b1;
            bus.i_data_we    = dq[0].we;
            bus.i_data_be    = dq[0].be;
            bus.i_data_addr  = dq[0].addr;
            bus.i_data_wdata = dq[0].wdata;
        end else begin
            bus.i_data_req   = 1'b0;
            bus.i_data_we    = 1'b0;
            bus.i_data_be    = 4'h0;
            bus.i_data_addr  = '0;
            bus.i_data_wdata = '0;
        end
        bus.i_mem_rdata = $urandom;
        bus.i_mem_ack   = 1'b0;

        e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_wdata = '0;
        if (m_owner == 1) begin
            e_req = bus.i_inst_req; e_be = 4'hF; e_addr = bus.i_inst_addr;
        end else if (m_owner == 2) begin
            e_req = bus.i_data_req; e_we = bus.i_data_we; e_be = bus.i_data_be;
            e_addr = bus.i_data_addr; e_wdata = bus.i_data_wdata;
        end
        if (e_req && mem_wait >= mem_lat) bus.i_mem_ack = 1'b1;
        #1;
        e_iack = (m_owner == 1) && bus.i_mem_ack;
        e_dack = (m_owner == 2) && bus.i_mem_ack;

        chk("mem_req", bus.o_mem_req, e_req);
        chk("mem_cmd", {bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata},
            {e_we, e_be, e_addr, e_wdata});
        chk("inst_ack", bus.o_inst_ack, e_iack);
        chk("data_ack", bus.o_data_ack, e_dack);
        chk("inst_rdata", bus.o_inst_rdata, (m_owner == 1) ? bus.i_mem_rdata : '0);
        chk("data_rdata", bus.o_data_rdata, (m_owner == 2) ? bus.i_mem_rdata : '0);
        chk("busy", bus.o_busy, (m_owner != 0));

        if (bus.o_inst_ack)      trace = {trace, "I"};
        else if (bus.o_data_ack) trace = {trace, "D"};
        else if (!bus.o_busy)    trace = {trace, "."};
        else                     trace = {trace, "-"};
        if (bus.o_data_ack) last_dcmd = {bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata};
        if (bus.o_mem_req && first_mreq < 0) first_mreq = scn_cyc;

        if (e_iack) begin inst_left--; inst_next = inst_next + 1; end
        if (e_dack) void'(dq.pop_front());
        if (!e_req || bus.i_mem_ack) new_lat();
        else mem_wait++;

        if (m_owner == 0) begin
            if (bus.i_inst_req && bus.i_data_req) m_owner = (m_last == 1) ? 2 : 1;
            else if (bus.i_inst_req)              m_owner = 1;
            else if (bus.i_data_req)              m_owner = 2;
            if (m_owner != 0) begin m_last = m_owner; m_words = 0; end
        end else begin
            r = (m_owner == 1) ? bus.i_inst_req : bus.i_data_req;
            if (r == 0) m_owner = 0;
            else if (bus.i_mem_ack) begin
                m_words++;
                if (!LOCK || m_words >= MAXB) m_owner = 0;
            end
        end
        scn_cyc++;
        @(posedge clk);
    endtask

    task automatic run(input string tag, input int limit);
        int n;
        n = 0;
        while ((inst_left > 0 || dq.size() > 0) && n < limit) begin cycle(); n++; end
        chk({tag, "_done"}, (inst_left == 0 && dq.size() == 0), 1'b1);
        repeat (4) cycle();
    endtask

    function automatic dtxn_t rnd_txn();
        dtxn_t t;
        t.we = 1'($urandom_range(0, 1));
        t.be = 4'($urandom);
        t.addr = $urandom;
        t.wdata = $urandom;
        return t;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fixed_lat = 2;
        inst_next = '0;
        rst = 1'b0;
        clear_inputs();
        bus.i_inst_req = 1'b1;
        bus.i_data_req = 1'b1;
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_rdata = 32'hCAFEF00D;
        #1;
        chk("rst_mem_req", bus.o_mem_req, 1'b0);
        chk("rst_acks", {bus.o_inst_ack, bus.o_data_ack}, 2'b00);
        chk("rst_rdata", {bus.o_inst_rdata, bus.o_data_rdata}, 64'h0);
        chk("rst_busy", bus.o_busy, 1'b0);

        // INST 16-word fill, memory answers on the third cycle of each request
        do_reset(); start_scn();
        fixed_lat = 2; new_lat();
        inst_left = 16; inst_next = 32'h1000;
        run("s1", 400);
        chk("s1_first_mreq", first_mreq, 1);
        chk("s1_seq", seq_code(trace), seq_code(rep("I", 16)));
        chk("s1_idle_gaps", idle_between(trace), LOCK ? 0 : 15);

        // both request at once after reset: INST first, then the DATA write
        do_reset(); start_scn();
        fixed_lat = 1; new_lat();
        inst_left = 4; inst_next = 32'h2000;
        dq.push_back('{1'b1, 4'hF, 32'h100, 32'hDEADBEEF});
        run("s2", 200);
        chk("s2_seq", seq_code(trace), seq_code(LOCK ? "IIIID" : "IDIII"));
        chk("s2_wr_cmd", last_dcmd, {1'b1, 4'hF, 32'h100, 32'hDEADBEEF});

        // 20-word INST stream with DATA waiting: forced release after MAX_BURST
        do_reset(); start_scn();
        fixed_lat = 1; new_lat();
        inst_left = 20; inst_next = 32'h3000;
        dq.push_back(rnd_txn());
        run("s3", 400);
        chk("s3_seq", seq_code(trace),
            seq_code(LOCK ? {rep("I", 16), "D", rep("I", 4)} : {"ID", rep("I", 19)}));

        // both requesting continuously, zero-latency memory
        do_reset(); start_scn();
        fixed_lat = 0; new_lat();
        inst_left = 6; inst_next = 32'h4000;
        for (int k = 0; k < 6; k++) dq.push_back(rnd_txn());
        run("s4", 200);
        chk("s4_seq", seq_code(trace),
            seq_code(LOCK ? {rep("I", 6), rep("D", 6)} : rep("ID", 6)));
        chk("s4_idle_gaps", idle_between(trace), LOCK ? 1 : 11);

        // reset asserted while a word is outstanding
        do_reset(); start_scn();
        fixed_lat = 3; new_lat();
        inst_left = 16; inst_next = 32'h5000;
        repeat (3) cycle();
        #1;
        rst = 1'b0;
        bus.i_mem_ack = 1'b1;
        bus.i_mem_rdata = 32'hA5A5A5A5;
        #1;
        chk("midrst_mem_req", bus.o_mem_req, 1'b0);
        chk("midrst_ack", {bus.o_inst_ack, bus.o_data_ack}, 2'b00);
        chk("midrst_cmd", {bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr, bus.o_mem_wdata}, 69'h0);
        chk("midrst_rdata", bus.o_inst_rdata, 32'h0);
        chk("midrst_busy", bus.o_busy, 1'b0);
        do_reset();

        // memory ack while idle is ignored
        start_scn();
        repeat (2) cycle();
        #1;
        bus.i_mem_ack = 1'b1;
        bus.i_mem_rdata = 32'h12345678;
        #1;
        chk("idle_ack", {bus.o_inst_ack, bus.o_data_ack}, 2'b00);
        chk("idle_rdata", {bus.o_inst_rdata, bus.o_data_rdata}, 64'h0);
        @(posedge clk);
        cycle();

        // randomized traffic against the ownership model
        do_reset(); start_scn();
        fixed_lat = -1; new_lat();
        for (int k = 0; k < 3000; k++) begin
            if (inst_left == 0 && $urandom_range(0, 3) == 0) begin
                inst_left = $urandom_range(1, 20);
                inst_next = $urandom;
            end
            if (dq.size() < 3 && $urandom_range(0, 2) == 0) dq.push_back(rnd_txn());
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
